quake_sta_lta_trigger: RTL

QUAKE_STA_LTA_TRIGGER -- requirements
Module: quake_sta_lta_trigger

---
 rtl/quake_sta_lta_trigger.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/quake_sta_lta_trigger.sv
// STA/LTA seismic trigger over |x|+|y|+|z|; state and alarm update 3 cycles after i_valid.
// No backpressure: a sample may arrive on every cycle and none is dropped.
module quake_sta_lta_trigger #(
    parameter int unsigned STA_SHIFT      = 3,
    parameter int unsigned LTA_SHIFT      = 7,
    parameter int unsigned RATIO_SHIFT    = 2,
    parameter logic [23:0] MIN_LEVEL      = 24'd50,
    parameter int unsigned WARMUP_SAMPLES = 256,
    parameter int unsigned HOLD_SAMPLES   = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [23:0] i_xdata,
    input  logic [23:0] i_ydata,
    input  logic [23:0] i_zdata,
    input  logic        i_accept,
    output logic        o_alarm,
    output logic [1:0]  o_state,
    output logic [23:0] o_sta,
    output logic [23:0] o_lta
);

    localparam int unsigned SW  = 24 + STA_SHIFT;
    localparam int unsigned LW  = 24 + LTA_SHIFT;
    localparam int unsigned WCW = $clog2(WARMUP_SAMPLES + 1);
    localparam int unsigned HCW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_SAMPLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_SAMPLES - 1);
    localparam logic [WCW-1:0] WARM_ONE  = WCW'(1);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_ARMED  = 2'd1,
        ST_TRIG   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    function automatic logic [23:0] abs24(input logic [23:0] v);
        abs24 = v[23] ? (~v + 24'd1) : v;
    endfunction

    // Stage 1: magnitude
    logic [25:0] m_sum;
    logic [23:0] m_sat;
    logic [23:0] m_q;
    logic        v1_q;

    assign m_sum = {2'b00, abs24(i_xdata)} + {2'b00, abs24(i_ydata)} + {2'b00, abs24(i_zdata)};
    assign m_sat = (m_sum[25:24] != 2'b00) ? 24'hFFFFFF : m_sum[23:0];

    // Stage 2: averages. acc - (acc >> S) + m is bounded by (2^24-1) << S, so it never wraps.
    logic [SW-1:0] acc_sta_q, acc_sta_d;
    logic [LW-1:0] acc_lta_q, acc_lta_d;
    logic          v2_q;
    logic          lta_frozen;

    assign acc_sta_d = acc_sta_q - (acc_sta_q >> STA_SHIFT) + {{STA_SHIFT{1'b0}}, m_q};
    assign acc_lta_d = acc_lta_q - (acc_lta_q >> LTA_SHIFT) + {{LTA_SHIFT{1'b0}}, m_q};

    assign o_sta = acc_sta_q[SW-1:STA_SHIFT];
    assign o_lta = acc_lta_q[LW-1:LTA_SHIFT];

    // Stage 3: trigger FSM
    state_t         state_q, state_d;
    logic           alarm_q, alarm_d;
    logic [WCW-1:0] warm_cnt_q, warm_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [25:0]    lta_scaled;
    logic           trig;

    assign lta_frozen = (state_q == ST_TRIG) || (state_q == ST_HOLD);
    assign lta_scaled = {2'b00, o_lta} << RATIO_SHIFT;
    assign trig       = ({2'b00, o_sta} >= lta_scaled) && (o_sta >= MIN_LEVEL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            m_q       <= '0;
            acc_sta_q <= '0;
            acc_lta_q <= '0;
        end else begin
            v1_q <= i_valid;
            v2_q <= v1_q;
            if (i_valid) begin
                m_q <= m_sat;
            end
            if (v1_q) begin
                acc_sta_q <= acc_sta_d;
                if (!lta_frozen) begin
                    acc_lta_q <= acc_lta_d;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_WARMUP;
            alarm_q    <= 1'b0;
            warm_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            alarm_q    <= alarm_d;
            warm_cnt_q <= warm_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alarm_d    = alarm_q;
        warm_cnt_d = warm_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_WARMUP: begin
                if (v2_q) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_ARMED;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_ONE;
                    end
                end
            end
            ST_ARMED: begin
                if (v2_q && trig) begin
                    state_d = ST_TRIG;
                    alarm_d = 1'b1;
                end
            end
            ST_TRIG: begin
                if (i_accept) begin
                    state_d    = ST_HOLD;
                    alarm_d    = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (v2_q) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_ARMED;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_WARMUP;
                alarm_d = 1'b0;
            end
        endcase
    end

    assign o_alarm = alarm_q;
    assign o_state = state_q;

endmodule
